shift_sequencer: RTL and testbench

Multi-cycle controller that performs a full 0–63 bit logical left shift of a 64-bit operand by iterating a 0–3 bit single-cycle shift stage, one step per clock. It sits between the execute-stage issue logic and the writeback path for the LSL and immediate-shift instructions. Operands enter and results leave through valid/ready handshakes, so the shift datapath is only occupied while a shift is in flight.

---
 rtl/shift_sequencer.sv | 95 +++++++++
 tb/tb_shift_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle 0-63 bit logical left shifter built from a 0-3 bit step stage, valid/ready on both
// sides. Define SHIFT_SEQ_ZERO_EXIT_EN to finish early once the accumulator becomes zero.
module shift_sequencer #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [4:0]         out_cycles,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [4:0]           cnt_q, cnt_d;

  logic [1:0]           step;
  logic [WIDTH-1:0]     acc_step;
  logic [SHAMT_W-1:0]   rem_step;

  // Single-cycle stage: shift by min(rem, 3).
  always_comb begin
    step     = (rem_q > SHAMT_W'(3)) ? 2'd3 : rem_q[1:0];
    acc_step = acc_q << step;
    rem_step = rem_q - {{(SHAMT_W-2){1'b0}}, step};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d = in_data;
          rem_d = in_shamt;
          cnt_d = '0;
          if (in_shamt == '0) state_d = StDone;
          else                state_d = StShift;
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
          if (in_data == '0) state_d = StDone;
`endif
        end
      end
      StShift: begin
        acc_d = acc_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (rem_step == '0) state_d = StDone;
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
        if (acc_step == '0) state_d = StDone;
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from registers or the state decode; no input-to-output paths.
  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    out_data   = acc_q;
    out_cycles = cnt_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized operations checked
// against an arithmetic model of result, step count and latency.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_cycles;
  logic        busy;

  int checks;
  int errors;

  shift_sequencer #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cycles (out_cycles),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: steps = ceil(s/3); with zero-exit, stop at the first step leaving zero.
  function automatic int exp_cycles(input logic [63:0] d, input int s);
    int n;
    n = (s + 2) / 3;
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
    if (d == 64'd0) return 0;
    for (int k = 1; k <= n; k++) begin
      if ((d << ((3 * k < s) ? 3 * k : s)) == 64'd0) return k;
    end
`endif
    return n;
  endfunction

  // Drives one operation with out_ready high and reports what was observed.
  task automatic do_op(input logic [63:0] d, input logic [5:0] s, output logic [63:0] got_d,
                       output logic [4:0] got_c, output int lat, output logic got_rdy,
                       output logic tmo);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_shamt = 6'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tmo     = !out_valid;
    got_d   = out_data;
    got_c   = out_cycles;
    @(negedge clk);
    got_rdy = in_ready;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_data, out_cycles} !== {1'b1, 1'b0, 1'b0, 64'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b data=%h cyc=%0d", in_ready, out_valid,
               busy, out_data, out_cycles);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic run_directed(input string name, input logic [63:0] d, input logic [5:0] s);
    logic [63:0] gd;
    logic [4:0]  gc;
    int          lat;
    logic        rdy;
    logic        tmo;
    do_op(d, s, gd, gc, lat, rdy, tmo);
    checks++;
    if (tmo !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout no out_valid within bound", name);
    end
    checks++;
    if (gd !== (d << s)) begin
      errors++;
      $display("FAIL %s_data got %h want %h", name, gd, d << s);
    end
    checks++;
    if (int'(gc) !== exp_cycles(d, int'(s))) begin
      errors++;
      $display("FAIL %s_cycles got %0d want %0d", name, gc, exp_cycles(d, int'(s)));
    end
    checks++;
    if (lat !== exp_cycles(d, int'(s))) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, exp_cycles(d, int'(s)));
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after got %b want 1", name, rdy);
    end
  endtask

  task automatic test_directed;
    run_directed("zero_shift", 64'hFFFF_FFFF_FFFF_FFFF, 6'd0);
    run_directed("remainder", 64'h1, 6'd7);
    run_directed("max_shift_1", 64'h1, 6'd63);
    run_directed("max_shift_3", 64'h3, 6'd63);
    run_directed("early_exit", 64'hF000_0000_0000_0000, 6'd60);
    run_directed("zero_data", 64'h0, 6'd10);
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hF;
    in_shamt  = 6'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data  = 64'h1234;
      in_shamt = 6'd1;
      checks++;
      if ({out_valid, out_data, out_cycles, in_ready, busy} !== {1'b1, 64'hF0, 5'd2, 1'b0, 1'b1})
      begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b data=%h cyc=%0d rdy=%b busy=%b", i, out_valid,
                 out_data, out_cycles, in_ready, busy);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_no_accept got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    in_shamt  = 6'd63;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, busy, in_ready} !== {1'b0, 64'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_async got vld=%b data=%h busy=%b rdy=%b", out_valid, out_data, busy,
               in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_result got out_valid=%b want 0", out_valid);
    end
    run_directed("after_reset", 64'h1, 6'd5);
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [5:0]  s;
    logic [63:0] gd;
    logic [4:0]  gc;
    int          lat;
    logic        rdy;
    logic        tmo;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 64'd0;
        1:       d = {$urandom, 32'd0};
        2:       d = 64'($urandom_range(1, 255));
        default: d = {$urandom, $urandom};
      endcase
      s = 6'($urandom_range(0, 63));
      do_op(d, s, gd, gc, lat, rdy, tmo);
      checks++;
      if (tmo !== 1'b0 || gd !== (d << s) || int'(gc) !== exp_cycles(d, int'(s)) ||
          lat !== exp_cycles(d, int'(s)) || rdy !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d d=%h s=%0d got data=%h cyc=%0d lat=%0d rdy=%b tmo=%b want data=%h cyc=%0d",
                 i, d, s, gd, gc, lat, rdy, tmo, d << s, exp_cycles(d, int'(s)));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
